// File: rtl/adder_arbiter.sv
`default_nettype none
// adder_arbiter: round-robin arbiter in front of one registered adder/subtractor with a valid/ready result.
// Optional feature: define ADDER_ARB_OVERFLOW_EN to build the registered signed-overflow flag.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [NUM_REQ-1:0]        req_in,
    input  logic [NUM_REQ-1:0]        sub_in,
    input  logic [NUM_REQ*DATA_W-1:0] op_a_in,
    input  logic [NUM_REQ*DATA_W-1:0] op_b_in,
    output logic [NUM_REQ-1:0]        gnt_out,
    output logic                      res_valid_out,
    input  logic                      res_ready_in,
    output logic [DATA_W-1:0]         res_data_out,
    output logic [ID_W-1:0]           res_id_out,
    output logic                      res_carry_out,
    output logic                      res_ovf_out
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]   data_q;
    logic [ID_W-1:0]     id_q;
    logic                carry_q;

    logic                accept;
    logic                found;
    logic                grant;
    logic [ID_W-1:0]     win;
    logic [ID_W:0]       cand;
    logic [NUM_REQ-1:0]  req_rot;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b_eff;
    logic                sub_sel;
    logic [DATA_W:0]     sum;

    assign accept  = (state_q == EMPTY) || res_ready_in;
    // Rotating a doubled copy puts the pointer's requester at bit 0.
    assign req_rot = NUM_REQ'({req_in, req_in} >> ptr_q);

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                cand  = {1'b0, ptr_q} + (ID_W+1)'(i);
                if (cand >= (ID_W+1)'(NUM_REQ)) begin
                    cand = cand - (ID_W+1)'(NUM_REQ);
                end
                win = cand[ID_W-1:0];
            end
        end
    end

    assign grant   = rst_n_in && accept && found;
    assign gnt_out = grant ? (NUM_REQ'(1) << win) : '0;

    always_comb begin
        op_a    = '0;
        op_b_eff = '0;
        sub_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                op_a     = op_a_in[i*DATA_W +: DATA_W];
                sub_sel  = sub_in[i];
                op_b_eff = sub_in[i] ? ~op_b_in[i*DATA_W +: DATA_W] : op_b_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sum = {1'b0, op_a} + {1'b0, op_b_eff} + {{DATA_W{1'b0}}, sub_sel};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (grant) begin
            state_d = FULL;
            ptr_d   = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end else if (state_q == FULL && res_ready_in) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (grant) begin
                data_q  <= sum[DATA_W-1:0];
                id_q    <= win;
                carry_q <= sum[DATA_W];
            end
        end
    end

`ifdef ADDER_ARB_OVERFLOW_EN
    logic ovf_q;
    logic ovf_d;

    assign ovf_d = (op_a[DATA_W-1] == op_b_eff[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ovf_q <= 1'b0;
        end else if (grant) begin
            ovf_q <= ovf_d;
        end
    end

    assign res_ovf_out = ovf_q;
`else
    assign res_ovf_out = 1'b0;
`endif

    assign res_valid_out = (state_q == FULL);
    assign res_data_out  = data_q;
    assign res_id_out    = id_q;
    assign res_carry_out = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// tb_adder_arbiter: directed vectors with a result scoreboard drained by an independent monitor.
module tb_adder_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;
`ifdef ADDER_ARB_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic                      clk_in = 1'b0;
    logic                      rst_n_in;
    logic [NUM_REQ-1:0]        req_in;
    logic [NUM_REQ-1:0]        sub_in;
    logic [NUM_REQ*DATA_W-1:0] op_a_in;
    logic [NUM_REQ*DATA_W-1:0] op_b_in;
    logic [NUM_REQ-1:0]        gnt_out;
    logic                      res_valid_out;
    logic                      res_ready_in;
    logic [DATA_W-1:0]         res_data_out;
    logic [ID_W-1:0]           res_id_out;
    logic                      res_carry_out;
    logic                      res_ovf_out;

    adder_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .req_in(req_in), .sub_in(sub_in),
        .op_a_in(op_a_in), .op_b_in(op_b_in), .gnt_out(gnt_out),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
        .res_data_out(res_data_out), .res_id_out(res_id_out),
        .res_carry_out(res_carry_out), .res_ovf_out(res_ovf_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic              carry;
        logic              ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic s);
        op_a_in[i*DATA_W +: DATA_W] = a;
        op_b_in[i*DATA_W +: DATA_W] = b;
        sub_in[i]                   = s;
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input int id, input logic c, input logic o);
        exp_t e;
        e.data  = d;
        e.id    = ID_W'(id);
        e.carry = c;
        e.ovf   = o;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_gnt(input string name, input logic [NUM_REQ-1:0] exp);
        @(negedge clk_in);
        check(name, 64'(gnt_out), 64'(exp));
    endtask

    // Results leave on an edge where valid and ready are both high.
    always @(negedge clk_in) begin
        if (rst_n_in && res_valid_out && res_ready_in) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got id %0d data %0h expected none", res_id_out, res_data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_data",  64'(res_data_out),  64'(e.data));
                check("res_id",    64'(res_id_out),    64'(e.id));
                check("res_carry", 64'(res_carry_out), 64'(e.carry));
                check("res_ovf",   64'(res_ovf_out),   64'(e.ovf));
            end
        end
    end

    localparam logic [NUM_REQ-1:0] RR_GNT [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        rst_n_in     = 1'b0;
        req_in       = 4'b1111;
        sub_in       = '0;
        op_a_in      = '0;
        op_b_in      = '0;
        res_ready_in = 1'b0;
        #12;
        check("rst_valid", 64'(res_valid_out), 64'd0);
        check("rst_data",  64'(res_data_out),  64'd0);
        check("rst_id",    64'(res_id_out),    64'd0);
        check("rst_carry", 64'(res_carry_out), 64'd0);
        check("rst_ovf",   64'(res_ovf_out),   64'd0);
        check("rst_gnt",   64'(gnt_out),       64'd0);

        cyc();
        rst_n_in = 1'b1;
        req_in   = '0;

        // Single request, then subtract/wrap vectors back to back.
        cyc();
        set_op(0, 32'h0000_0004, 32'h0040_0000, 1'b0);
        req_in = 4'b0001; res_ready_in = 1'b1;
        push(32'h0040_0004, 0, 1'b0, 1'b0);
        chk_gnt("single_gnt", 4'b0001);
        check("single_valid_lat", 64'(res_valid_out), 64'd0);

        cyc();
        set_op(1, 32'h0000_0000, 32'h0000_0001, 1'b1);
        req_in = 4'b0010;
        push(32'hFFFF_FFFF, 1, 1'b0, 1'b0);
        chk_gnt("sub_gnt", 4'b0010);

        cyc();
        set_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        req_in = 4'b0100;
        push(32'h0000_0000, 2, 1'b1, 1'b0);
        chk_gnt("wrap_gnt", 4'b0100);

        cyc();
        set_op(3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        req_in = 4'b1000;
        push(32'h8000_0000, 3, 1'b0, OVF_EXP);
        chk_gnt("ovf_gnt", 4'b1000);

        // Round robin with all requests held.
        cyc();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, DATA_W'(i * 32'h10), DATA_W'(32'h100 + i), 1'b0);
        req_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) cyc();
            push(DATA_W'(((k % 4) * 32'h10) + 32'h100 + (k % 4)), k % 4, 1'b0, 1'b0);
            chk_gnt($sformatf("rr_gnt%0d", k), RR_GNT[k]);
        end

        // Backpressure: last round-robin result (id 0) must sit still.
        cyc();
        req_in = 4'b0110; res_ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) cyc();
            chk_gnt($sformatf("bp_gnt%0d", k), 4'b0000);
            check("bp_valid", 64'(res_valid_out), 64'd1);
            check("bp_data",  64'(res_data_out),  64'h100);
            check("bp_id",    64'(res_id_out),    64'd0);
        end
        cyc();
        res_ready_in = 1'b1;
        push(32'h0000_0111, 1, 1'b0, 1'b0);
        chk_gnt("bp_release_gnt", 4'b0010);
        cyc();
        req_in = 4'b0100;
        push(32'h0000_0122, 2, 1'b0, 1'b0);
        chk_gnt("bp_next_gnt", 4'b0100);

        // Asynchronous reset while holding the id 2 result.
        cyc();
        req_in = 4'b1111; res_ready_in = 1'b0;
        #1;
        check("pre_rst_valid", 64'(res_valid_out), 64'd1);
        check("pre_rst_id",    64'(res_id_out),    64'd2);
        rst_n_in = 1'b0;
        sb.delete();
        #1;
        check("arst_valid", 64'(res_valid_out), 64'd0);
        check("arst_data",  64'(res_data_out),  64'd0);
        check("arst_id",    64'(res_id_out),    64'd0);
        check("arst_carry", 64'(res_carry_out), 64'd0);
        check("arst_ovf",   64'(res_ovf_out),   64'd0);
        check("arst_gnt",   64'(gnt_out),       64'd0);

        cyc();
        rst_n_in = 1'b1;
        req_in = 4'b1000; res_ready_in = 1'b1;
        set_op(3, 32'h0000_0005, 32'h0000_0006, 1'b0);
        push(32'h0000_000B, 3, 1'b0, 1'b0);
        chk_gnt("post_rst_gnt", 4'b1000);
        cyc();
        req_in = '0;
        @(negedge clk_in);
        check("post_rst_valid", 64'(res_valid_out), 64'd1);

        repeat (3) cyc();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter sharing one registered 32-bit adder/subtractor among several datapath requesters (PC increment, branch-target, address-generation units). Each cycle at most one request is granted, its operands are summed and the result is held in a single output register with a valid/ready handshake until the consumer accepts it. Sits between the requesting datapath units and the shared adder resource, replacing per-unit adders.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width
- ID_W, 2, requester index width (= clog2(NUM_REQ), min 1)

- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- req_in  input  NUM_REQ  per-requester request, held until granted
- sub_in  input  NUM_REQ  per-requester mode: 0 = A+B, 1 = A-B
- op_a_in  input  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W]
- op_b_in  input  NUM_REQ*DATA_W  operand B, same packing
- gnt_out  output  NUM_REQ  one-hot grant; operands captured on that edge
- res_valid_out  output  1  result register full
- res_ready_in  input  1  consumer accepts result
- res_data_out  output  DATA_W  sum/difference
- res_id_out  output  ID_W  index of requester owning result
- res_carry_out  output  1  carry out of MSB
- res_ovf_out  output  1  signed overflow (see Configuration)

## Operation
- State machine, 2 states: EMPTY (res_valid_out=0), FULL (res_valid_out=1).
- accept = !res_valid_out || res_ready_in. Grant only when accept=1 and any req_in set.
- Winner: first set req_in bit searching upward from pointer ptr, wrapping modulo NUM_REQ. gnt_out combinational, one-hot, zero when no grant.
- On grant to k: result register loads op_a[k] + (sub[k] ? ~op_b[k] : op_b[k]) + sub[k], computed at DATA_W+1 bits; res_carry = bit DATA_W (raw carry, no borrow inversion); res_id = k; ptr <= (k+1) mod NUM_REQ; state -> FULL.
- FULL with res_ready_in=1 and no grant -> EMPTY. FULL with res_ready_in=1 and grant -> stays FULL with new result (drain and load same edge).
- FULL with res_ready_in=0: result, id, flags stable; gnt_out=0; ptr unchanged.
- Requester drops req_in only after seeing its gnt_out bit high; dropping earlier is legal and simply removes it from arbitration.
- Wrap-around of sums is modulo 2^DATA_W; carry reports the overflowed bit.
- Reset (any time, including FULL mid-handshake): res_valid_out=0, res_data_out=0, res_id_out=0, res_carry_out=0, res_ovf_out=0, ptr=0, state EMPTY; in-flight result is discarded; gnt_out=0 while rst_n_in low.

## Timing
- Latency: grant in cycle N -> res_valid_out high in cycle N+1.
- Throughput: one result per cycle when res_ready_in held high.
- No combinational path from req_in to res_* outputs; gnt_out depends combinationally on req_in, res_valid_out, res_ready_in, ptr.
- Starvation bound: a held request is granted within NUM_REQ grants.

## Configuration
- ADDER_ARB_OVERFLOW_EN defined: res_ovf_out registered with result = signed overflow of the effective addition (operand A sign equals effective-B sign and result sign differs).
- Undefined: overflow logic not built; res_ovf_out tied 0. All other behaviour identical.

## Test plan
- Single request: req_in=0001, A=0x00000004, B=0x00400000, sub=0, ready=1 -> gnt_out=0001 cycle N; cycle N+1 valid=1, data=0x00400004, id=0, carry=0.
- Subtract/wrap: A=0x00000000, B=0x00000001, sub=1 -> data=0xFFFFFFFF, carry=0; A=0xFFFFFFFF,B=1,add -> data=0, carry=1; with macro A=0x7FFFFFFF,B=1 add -> ovf=1, without macro ovf=0.
- Round-robin: req_in=1111 held, ready=1 -> grants 0001,0010,0100,1000,0001 on consecutive cycles, res_id 0,1,2,3,0.
- Backpressure: result FULL, ready=0 for 5 cycles with req_in=0110 -> gnt_out=0, outputs stable; ready=1 -> same-cycle grant to requester 1 (ptr order), next result id=1.
- Reset mid-operation: FULL with id=2, assert rst_n_in low asynchronously -> valid, data, id, flags=0 immediately; after release with req_in=1000 -> first grant 1000 (ptr=0 search wraps), valid next cycle.
